// File: rtl/alu_pkg.sv
// Shared encodings for the registered ALU: operation selects and controller states.
package alu_pkg;

    localparam logic [1:0] OP_NEGB = 2'b00;
    localparam logic [1:0] OP_NEGA = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOT  = 2'b11;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational arithmetic/logic unit: result, carry and signed overflow for one operation.
module alu_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             l_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_o,
    output logic             v_o
);
    import alu_pkg::*;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Every arithmetic op is x + y + cin, so carry and overflow come from one adder.
    always_comb begin
        x   = a_i;
        y   = b_i;
        cin = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                x   = a_i;
                y   = b_i;
                cin = 1'b0;
            end
            OP_SUB: begin
                y   = ~b_i;
                cin = 1'b1;
            end
            OP_NEGA: begin
                x   = '0;
                y   = ~a_i;
                cin = 1'b1;
            end
            OP_NEGB: begin
                x   = '0;
                y   = ~b_i;
                cin = 1'b1;
            end
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        result_o = sum[WIDTH-1:0];
        c_o      = sum[WIDTH];
        v_o      = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        if (l_i) begin
            c_o = 1'b0;
            v_o = 1'b0;
            unique case (op_i)
                OP_AND: result_o = a_i & b_i;
                OP_OR:  result_o = a_i | b_i;
                OP_XOR: result_o = a_i ^ b_i;
                OP_NOT: result_o = ~a_i;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake, accumulator operand and a WIDTH-cycle
// unsigned shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    input  logic             L,
    input  logic             mul,
    input  logic             acc_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] RH,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             v
);
    import alu_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] ph_q;

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] core_r;
    logic             core_c;
    logic             core_v;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] ph_d;
    logic [WIDTH-1:0] mplier_d;

    assign operand = acc_sel ? R : A;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a_i     (operand),
        .b_i     (B),
        .op_i    (Op),
        .l_i     (L),
        .result_o(core_r),
        .c_o     (core_c),
        .v_o     (core_v)
    );

    // The multiplier register doubles as the low product half: product bits shift in
    // at the top as consumed multiplier bits leave at the bottom.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        step_sum = {1'b0, ph_q} + {1'b0, addend};
        ph_d     = step_sum[WIDTH:1];
        mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            ph_q     <= '0;
            R        <= '0;
            RH       <= '0;
            z        <= 1'b1;
            c        <= 1'b0;
            s        <= 1'b0;
            v        <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mul) begin
                            mcand_q  <= operand;
                            mplier_q <= B;
                            ph_q     <= '0;
                            cnt_q    <= '0;
                            busy     <= 1'b1;
                            state_q  <= MUL;
                        end else begin
                            R    <= core_r;
                            RH   <= '0;
                            z    <= ~|core_r;
                            c    <= core_c;
                            s    <= core_r[WIDTH-1];
                            v    <= core_v;
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    ph_q     <= ph_d;
                    mplier_q <= mplier_d;
                    if (cnt_q == LAST_STEP) begin
                        R       <= mplier_d;
                        RH      <= ph_d;
                        z       <= ~|mplier_d;
                        c       <= |ph_d;
                        s       <= ph_d[WIDTH-1];
                        v       <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
